// File: rtl/matching_engine_pq.sv
// matching_engine_pq
// Two sliding order windows (bids and asks), DEPTH entries each, newest at
// index 0. Each cycle the best bid (highest price) and best ask (lowest
// price) are found among live entries. If they cross, one trade executes
// for the smaller of the two quantities. Partial fills decrement the
// remaining quantity, and an entry whose quantity reaches zero retires.
// After the match, newly arriving orders shift into their window.
module matching_engine_pq #(
  parameter int PW    = 8,
  parameter int QW    = 8,
  parameter int DEPTH = 8,
  parameter int MODE  = 0,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          buy_valid,
  input  logic [PW-1:0] buy_price,
  input  logic [QW-1:0] buy_qty,
  input  logic          sell_valid,
  input  logic [PW-1:0] sell_price,
  input  logic [QW-1:0] sell_qty,
  output logic [PW-1:0] best_bid,
  output logic [PW-1:0] best_ask,
  output logic          bid_empty,
  output logic          ask_empty,
  output logic          trade_valid,
  output logic [PW-1:0] trade_price,
  output logic [QW-1:0] trade_qty,
  output logic [CW-1:0] trade_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Window storage, index 0 is the newest entry
  logic          r_bid_live  [DEPTH];
  logic [PW-1:0] r_bid_price [DEPTH];
  logic [QW-1:0] r_bid_qty   [DEPTH];
  logic          r_ask_live  [DEPTH];
  logic [PW-1:0] r_ask_price [DEPTH];
  logic [QW-1:0] r_ask_qty   [DEPTH];

  logic          r_trade_valid;
  logic [PW-1:0] r_trade_price;
  logic [QW-1:0] r_trade_qty;
  logic [CW-1:0] r_trade_count;

  // Best-entry selection results
  logic          w_bid_found;
  logic [PW-1:0] w_bid_sel_price;
  logic [QW-1:0] w_bid_sel_qty;
  logic [IW-1:0] w_bid_sel_idx;
  logic          w_ask_found;
  logic [PW-1:0] w_ask_sel_price;
  logic [QW-1:0] w_ask_sel_qty;
  logic [IW-1:0] w_ask_sel_idx;

  // Match stage
  logic          w_match;
  logic [QW-1:0] w_fill_qty;
  logic [PW:0]   w_mid_sum;
  logic [PW-1:0] w_trade_price;

  // Insert decisions
  logic          w_buy_ins;
  logic          w_sell_ins;

  // Windows after the match is applied, and after the shift/insert
  logic          w_bid_live_m [DEPTH];
  logic [QW-1:0] w_bid_qty_m  [DEPTH];
  logic          w_ask_live_m [DEPTH];
  logic [QW-1:0] w_ask_qty_m  [DEPTH];
  logic          w_bid_live_n  [DEPTH];
  logic [PW-1:0] w_bid_price_n [DEPTH];
  logic [QW-1:0] w_bid_qty_n   [DEPTH];
  logic          w_ask_live_n  [DEPTH];
  logic [PW-1:0] w_ask_price_n [DEPTH];
  logic [QW-1:0] w_ask_qty_n   [DEPTH];

  // Pick the highest live bid; scanning upward with >= hands ties to the oldest entry
  always_comb begin
    w_bid_found     = 1'b0;
    w_bid_sel_price = '0;
    w_bid_sel_qty   = '0;
    w_bid_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_bid_live[i] && (!w_bid_found || (r_bid_price[i] >= w_bid_sel_price))) begin
        w_bid_found     = 1'b1;
        w_bid_sel_price = r_bid_price[i];
        w_bid_sel_qty   = r_bid_qty[i];
        w_bid_sel_idx   = IW'(i);
      end
    end
  end

  // Pick the lowest live ask; scanning upward with <= hands ties to the oldest entry
  always_comb begin
    w_ask_found     = 1'b0;
    w_ask_sel_price = '0;
    w_ask_sel_qty   = '0;
    w_ask_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ask_live[i] && (!w_ask_found || (r_ask_price[i] <= w_ask_sel_price))) begin
        w_ask_found     = 1'b1;
        w_ask_sel_price = r_ask_price[i];
        w_ask_sel_qty   = r_ask_qty[i];
        w_ask_sel_idx   = IW'(i);
      end
    end
  end

  assign best_bid  = w_bid_found ? w_bid_sel_price : '0;
  assign best_ask  = w_ask_found ? w_ask_sel_price : '1;
  assign bid_empty = ~w_bid_found;
  assign ask_empty = ~w_ask_found;

  // The sum is widened by one bit so the midpoint never wraps
  assign w_match       = w_bid_found && w_ask_found && (w_bid_sel_price >= w_ask_sel_price);
  assign w_fill_qty    = (w_bid_sel_qty < w_ask_sel_qty) ? w_bid_sel_qty : w_ask_sel_qty;
  assign w_mid_sum     = {1'b0, w_bid_sel_price} + {1'b0, w_ask_sel_price};
  assign w_trade_price = (MODE == 1) ? w_ask_sel_price : w_mid_sum[PW:1];

  // Zero-quantity orders carry nothing to trade, so they do not disturb the window
  assign w_buy_ins  = buy_valid && (buy_qty != '0);
  assign w_sell_ins = sell_valid && (sell_qty != '0);

  // Per-entry match application followed by the shift into the next-state windows
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign w_bid_qty_m[gi]  = (w_match && (w_bid_sel_idx == IW'(gi)))
                              ? (r_bid_qty[gi] - w_fill_qty) : r_bid_qty[gi];
    assign w_ask_qty_m[gi]  = (w_match && (w_ask_sel_idx == IW'(gi)))
                              ? (r_ask_qty[gi] - w_fill_qty) : r_ask_qty[gi];
    assign w_bid_live_m[gi] = r_bid_live[gi] && (w_bid_qty_m[gi] != '0);
    assign w_ask_live_m[gi] = r_ask_live[gi] && (w_ask_qty_m[gi] != '0);

    if (gi == 0) begin : g_head
      assign w_bid_live_n[gi]  = w_buy_ins  ? 1'b1       : w_bid_live_m[gi];
      assign w_bid_price_n[gi] = w_buy_ins  ? buy_price  : r_bid_price[gi];
      assign w_bid_qty_n[gi]   = w_buy_ins  ? buy_qty    : w_bid_qty_m[gi];
      assign w_ask_live_n[gi]  = w_sell_ins ? 1'b1       : w_ask_live_m[gi];
      assign w_ask_price_n[gi] = w_sell_ins ? sell_price : r_ask_price[gi];
      assign w_ask_qty_n[gi]   = w_sell_ins ? sell_qty   : w_ask_qty_m[gi];
    end else begin : g_body
      assign w_bid_live_n[gi]  = w_buy_ins  ? w_bid_live_m[gi-1] : w_bid_live_m[gi];
      assign w_bid_price_n[gi] = w_buy_ins  ? r_bid_price[gi-1]  : r_bid_price[gi];
      assign w_bid_qty_n[gi]   = w_buy_ins  ? w_bid_qty_m[gi-1]  : w_bid_qty_m[gi];
      assign w_ask_live_n[gi]  = w_sell_ins ? w_ask_live_m[gi-1] : w_ask_live_m[gi];
      assign w_ask_price_n[gi] = w_sell_ins ? r_ask_price[gi-1]  : r_ask_price[gi];
      assign w_ask_qty_n[gi]   = w_sell_ins ? w_ask_qty_m[gi-1]  : w_ask_qty_m[gi];
    end
  end

  // Window state: reset and flush clear everything, otherwise load match+shift result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bid_live[i]  <= 1'b0;
        r_bid_price[i] <= '0;
        r_bid_qty[i]   <= '0;
        r_ask_live[i]  <= 1'b0;
        r_ask_price[i] <= '0;
        r_ask_qty[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bid_live[i]  <= 1'b0;
        r_bid_price[i] <= '0;
        r_bid_qty[i]   <= '0;
        r_ask_live[i]  <= 1'b0;
        r_ask_price[i] <= '0;
        r_ask_qty[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bid_live[i]  <= w_bid_live_n[i];
        r_bid_price[i] <= w_bid_price_n[i];
        r_bid_qty[i]   <= w_bid_qty_n[i];
        r_ask_live[i]  <= w_ask_live_n[i];
        r_ask_price[i] <= w_ask_price_n[i];
        r_ask_qty[i]   <= w_ask_qty_n[i];
      end
    end
  end

  // Trade report: pulse on a match; price and qty hold their last values otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trade_valid <= 1'b0;
      r_trade_price <= '0;
      r_trade_qty   <= '0;
      r_trade_count <= '0;
    end else if (flush) begin
      r_trade_valid <= 1'b0;
      r_trade_count <= '0;
    end else begin
      r_trade_valid <= w_match;
      if (w_match) begin
        r_trade_price <= w_trade_price;
        r_trade_qty   <= w_fill_qty;
        if (r_trade_count != '1) begin
          r_trade_count <= r_trade_count + 1'b1;
        end
      end
    end
  end

  assign trade_valid = r_trade_valid;
  assign trade_price = r_trade_price;
  assign trade_qty   = r_trade_qty;
  assign trade_count = r_trade_count;

endmodule

// File: tb/tb_matching_engine_pq.sv
// Directed bench for matching_engine_pq. Two instances share the stimulus:
// u_dut0 uses the midpoint price rule, u_dut1 the resting-ask price rule.
module tb_matching_engine_pq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       buy_valid, sell_valid;
  logic [7:0] buy_price, buy_qty, sell_price, sell_qty;

  logic [7:0]  best_bid0, best_ask0, trade_price0, trade_qty0;
  logic        bid_empty0, ask_empty0, trade_valid0;
  logic [15:0] trade_count0;
  logic [7:0]  best_bid1, best_ask1, trade_price1, trade_qty1;
  logic        bid_empty1, ask_empty1, trade_valid1;
  logic [15:0] trade_count1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matching_engine_pq #(.PW(8), .QW(8), .DEPTH(8), .MODE(0), .CW(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .buy_valid(buy_valid), .buy_price(buy_price), .buy_qty(buy_qty),
    .sell_valid(sell_valid), .sell_price(sell_price), .sell_qty(sell_qty),
    .best_bid(best_bid0), .best_ask(best_ask0),
    .bid_empty(bid_empty0), .ask_empty(ask_empty0),
    .trade_valid(trade_valid0), .trade_price(trade_price0),
    .trade_qty(trade_qty0), .trade_count(trade_count0)
  );

  matching_engine_pq #(.PW(8), .QW(8), .DEPTH(8), .MODE(1), .CW(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .buy_valid(buy_valid), .buy_price(buy_price), .buy_qty(buy_qty),
    .sell_valid(sell_valid), .sell_price(sell_price), .sell_qty(sell_qty),
    .best_bid(best_bid1), .best_ask(best_ask1),
    .bid_empty(bid_empty1), .ask_empty(ask_empty1),
    .trade_valid(trade_valid1), .trade_price(trade_price1),
    .trade_qty(trade_qty1), .trade_count(trade_count1)
  );

  typedef struct {
    logic        bv;
    logic [7:0]  bp, bq;
    logic        sv;
    logic [7:0]  sp, sq;
    logic        fl;
    logic [7:0]  e_bid, e_ask;
    logic        e_tv;
    logic [7:0]  e_px0, e_px1, e_qty;
    logic [15:0] e_cnt;
    logic        chk_pq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int bv, int bp, int bq, int sv, int sp, int sq, int fl,
                              int ebid, int eask, int etv, int epx0, int epx1,
                              int eqty, int ecnt, int chk);
    vec_t v;
    v.bv = 1'(bv);  v.bp = 8'(bp);  v.bq = 8'(bq);
    v.sv = 1'(sv);  v.sp = 8'(sp);  v.sq = 8'(sq);
    v.fl = 1'(fl);
    v.e_bid = 8'(ebid); v.e_ask = 8'(eask); v.e_tv = 1'(etv);
    v.e_px0 = 8'(epx0); v.e_px1 = 8'(epx1); v.e_qty = 8'(eqty);
    v.e_cnt = 16'(ecnt); v.chk_pq = 1'(chk);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " best_bid"},    int'(best_bid0), 0);
    chk({tag, " best_ask"},    int'(best_ask0), 255);
    chk({tag, " bid_empty"},   int'(bid_empty0), 1);
    chk({tag, " ask_empty"},   int'(ask_empty0), 1);
    chk({tag, " trade_valid"}, int'(trade_valid0), 0);
    chk({tag, " trade_price"}, int'(trade_price0), 0);
    chk({tag, " trade_qty"},   int'(trade_qty0), 0);
    chk({tag, " trade_count"}, int'(trade_count0), 0);
    chk({tag, " m1 trade_valid"}, int'(trade_valid1), 0);
    chk({tag, " m1 trade_count"}, int'(trade_count1), 0);
  endtask

  task automatic drive(input vec_t v);
    buy_valid  = v.bv;  buy_price  = v.bp;  buy_qty  = v.bq;
    sell_valid = v.sv;  sell_price = v.sp;  sell_qty = v.sq;
    flush      = v.fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
  endtask

  initial begin
    vec_t v;
    string tag;

    // ---------------- vector table ----------------
    // No-cross fill: one buy/sell pair per cycle
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 60 + 2*i, 10, 1, 90 - 2*i, 10, 0,
                        60 + 2*i, 90 - 2*i, 0, 0, 0, 0, 0, 1));
    // Ninth pair evicts 60/90, best unchanged
    vecs.push_back(mk(1, 50, 10, 1, 95, 10, 0, 74, 76, 0, 0, 0, 0, 0, 1));
    // Full cross: buy 80 alone, trade next cycle at 78 (mid) / 76 (ask)
    vecs.push_back(mk(1, 80, 10, 0, 0, 0, 0, 80, 76, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 74, 78, 1, 78, 76, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 74, 78, 0, 78, 76, 10, 1, 1));
    // Partial fill: buy 85 q4 vs sell 60 q10
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 85, 4, 0, 0, 0, 0, 85, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 60, 10, 0, 85, 60, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 60, 1, 72, 60, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 60, 0, 72, 60, 4, 1, 1));
    // Multi-cycle sweep: asks 70 q3 / 72 q3, buy 80 q5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 70, 3, 0, 0, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 72, 3, 0, 0, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 80, 5, 0, 0, 0, 0, 80, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 80, 72, 1, 75, 70, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 72, 1, 76, 72, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 72, 0, 76, 72, 2, 2, 1));
    // Equal ask prices: the older (q2) fills first, then the newer (q5)
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 70, 2, 0, 0, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 70, 5, 0, 0, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 75, 9, 0, 0, 0, 0, 75, 70, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 75, 70, 1, 72, 70, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 75, 255, 1, 72, 70, 5, 2, 1));
    // Zero-qty order ignored; then a cross pending is killed by flush
    vecs.push_back(mk(1, 99, 0, 1, 10, 0, 0, 75, 255, 0, 72, 70, 5, 2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 70, 1, 0, 75, 70, 0, 72, 70, 5, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 255, 0, 0, 0, 0, 0, 0));
    // Eviction: bid 90 ages out after 8 further buys, best falls to 80
    vecs.push_back(mk(1, 90, 5, 0, 0, 0, 0, 90, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 80, 5, 0, 0, 0, 0, 90, 255, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 50 + i, 5, 0, 0, 0, 0, 90, 255, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 56, 5, 0, 0, 0, 0, 80, 255, 0, 0, 0, 0, 0, 0));

    // ---------------- reset with orders driven ----------------
    reset_n    = 1'b0;
    flush      = 1'b0;
    buy_valid  = 1'b1; buy_price  = 8'd100; buy_qty  = 8'd5;
    sell_valid = 1'b1; sell_price = 8'd50;  sell_qty = 8'd5;
    repeat (5) @(posedge clk);
    #1;
    $display("reset: bid=%0d ask=%0d tv=%0d cnt=%0d", best_bid0, best_ask0, trade_valid0, trade_count0);
    check_reset_state("reset");
    @(negedge clk);
    buy_valid = 1'b0; sell_valid = 1'b0;
    reset_n = 1'b1;

    // ---------------- table ----------------
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      drive(v);
      $display("vec %0d: bid=%0d ask=%0d tv=%0d px=%0d/%0d qty=%0d cnt=%0d",
               k, best_bid0, best_ask0, trade_valid0, trade_price0, trade_price1,
               trade_qty0, trade_count0);
      tag = $sformatf("vec%0d", k);
      chk({tag, " best_bid"},    int'(best_bid0), int'(v.e_bid));
      chk({tag, " best_ask"},    int'(best_ask0), int'(v.e_ask));
      chk({tag, " bid_empty"},   int'(bid_empty0), (v.e_bid == 8'd0) ? 1 : 0);
      chk({tag, " ask_empty"},   int'(ask_empty0), (v.e_ask == 8'd255) ? 1 : 0);
      chk({tag, " trade_valid"}, int'(trade_valid0), int'(v.e_tv));
      chk({tag, " trade_count"}, int'(trade_count0), int'(v.e_cnt));
      chk({tag, " m1 trade_valid"}, int'(trade_valid1), int'(v.e_tv));
      chk({tag, " m1 trade_count"}, int'(trade_count1), int'(v.e_cnt));
      if (v.chk_pq) begin
        chk({tag, " trade_price"},    int'(trade_price0), int'(v.e_px0));
        chk({tag, " m1 trade_price"}, int'(trade_price1), int'(v.e_px1));
        chk({tag, " trade_qty"},      int'(trade_qty0), int'(v.e_qty));
      end
    end

    // ---------------- async reset in the middle of a sweep ----------------
    v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    v = mk(0, 0, 0, 1, 70, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    v = mk(0, 0, 0, 1, 72, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    v = mk(1, 80, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    idle_cycle();
    $display("sweep: tv=%0d px=%0d qty=%0d cnt=%0d", trade_valid1, trade_price1, trade_qty1, trade_count1);
    chk("sweep1 trade_valid", int'(trade_valid1), 1);
    chk("sweep1 m1 trade_price", int'(trade_price1), 70);
    chk("sweep1 trade_qty", int'(trade_qty1), 3);
    // Drop reset between edges; outputs must clear without waiting for a clock
    reset_n = 1'b0;
    #1;
    $display("midreset: bid=%0d ask=%0d tv=%0d cnt=%0d", best_bid0, best_ask0, trade_valid0, trade_count0);
    check_reset_state("midreset");
    chk("midreset m1 best_ask", int'(best_ask1), 255);
    chk("midreset m1 trade_price", int'(trade_price1), 0);
    @(posedge clk);
    #1;
    chk("midreset held trade_valid", int'(trade_valid1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycle();
    chk("postreset trade_valid", int'(trade_valid0), 0);
    chk("postreset best_bid", int'(best_bid0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matching_engine_pq.md
Name: matching_engine_pq

Overview:
- Parametrised successor to the 8-bit matching engine: per-side sliding windows of the last DEPTH valid orders (price + quantity).
- Tracks best bid (max) and best ask (min) over live entries and executes at most one trade per cycle when best_bid >= best_ask.
- Fills are partial: quantities decrement, and exhausted entries retire.
- Sits between the order-capture front end and the trade reporting / statistics logic.

Parameters:
PW, 8, price width in bits
QW, 8, quantity width in bits
DEPTH, 8, window entries per side (>=2)
MODE, 0, trade price rule: 0 = midpoint, 1 = resting ask price
CW, 16, trade counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of both windows
buy_valid  in  1  buy order present this cycle
buy_price  in  PW  buy price
buy_qty  in  QW  buy quantity
sell_valid  in  1  sell order present this cycle
sell_price  in  PW  sell price
sell_qty  in  QW  sell quantity
best_bid  out  PW  max live bid price; 0 when bid side empty
best_ask  out  PW  min live ask price; all-ones when ask side empty
bid_empty  out  1  no live bid entries
ask_empty  out  1  no live ask entries
trade_valid  out  1  one-cycle trade pulse
trade_price  out  PW  executed price
trade_qty  out  QW  executed quantity
trade_count  out  CW  total trades since reset/flush, saturating

Behaviour:
- Reset (reset_n low, async): all entries invalid, qty 0; trade_valid 0; trade_price 0; trade_qty 0; trade_count 0. Consequently best_bid 0, best_ask all-ones, both empty flags 1.
- Each side is a shift register of DEPTH entries {live, price, qty}. Index 0 is newest.
- best_bid, best_ask and the empty flags are combinational from the window registers. They reflect state after the most recent edge.
- Best entry selection: max price (bid) or min price (ask) among live entries. Ties go to the oldest entry (highest index).
- Per-edge order of operations, all in one clock:
  1. Match on current window. Condition: both sides non-empty and best_bid >= best_ask.
     - q = min(bid qty, ask qty).
     - Both selected entries decrement by q; an entry reaching 0 becomes not live.
     - Register trade_valid=1, trade_qty=q.
     - trade_price = MODE 0: (best_bid+best_ask)>>1, computed at PW+1 bits, result floored. MODE 1: best_ask.
     - trade_count increments, saturating at 2^CW-1.
     - If no match: trade_valid=0; trade_price and trade_qty hold their previous values.
  2. Shift: for each side independently, if valid and qty!=0, shift the window by one and insert the new entry at index 0, live. The entry at DEPTH-1 is discarded whether live or not. Valid with qty==0 is ignored (no shift).
- Latency: an order inserted at edge N can first trade at edge N+1. trade_valid is visible after edge N+1.
- An entry matched and evicted in the same cycle: the match applies first, so the trade is reported and the entry is then gone.
- Only one trade per cycle. A residual cross (remaining qty, or the next-best entry still crossing) trades on subsequent cycles.
- flush=1 (sync, priority over match and insert): windows cleared, trade_count 0, trade_valid 0.
- Reset mid-operation overrides everything immediately; no trade is emitted.

Test Plan:
1. Reset: hold reset_n=0 for 5 cycles with valid orders driven -> best_bid=0, best_ask=255, bid_empty=ask_empty=1, trade_valid=0, trade_count=0.
2. No-cross fill: buys 60,62,...,74 and sells 90,88,...,76, qty 10, one pair per cycle -> best_bid=74, best_ask=76, no trades. A 9th pair buy 50 / sell 95 evicts 60/90 -> best stays 74/76.
3. Full cross, MODE=0: from state 2 insert buy 80 q10 only -> next cycle trade_valid=1, price 78, qty 10, trade_count=1. Afterwards best_bid=74, best_ask=78, no further trade.
4. Partial fill: empty book; buy 85 q4, then sell 60 q10 -> trade price 72, qty 4. Bid side empty; ask 60 remains live with qty 6, best_ask=60.
5. Multi-cycle sweep, MODE=1: asks 70 q3 and 72 q3 live; insert buy 80 q5 -> cycle 1: trade 70 q3; cycle 2: trade 72 q2; ask 72 keeps qty 1; trade_count=2.
6. Eviction, flush and reset: best bid 90 aged out after DEPTH further buys -> best_bid drops to the next max. flush with a cross pending -> no trade, empty book, count 0. reset_n low mid-sweep -> outputs reset asynchronously.
